// File: rtl/mem_bus_responder_pkg.sv
// Shared types and request-decode helpers for the memory-side bus responder.
// Holds the FSM state encoding, the latched operation code and the fault rule.
package mem_bus_responder_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A request faults on ambiguous strobes, a misaligned word address, or any
  // address bit set above the backing store.
  function automatic logic req_fault(input logic        rd,
                                     input logic        wr,
                                     input logic [31:0] addr,
                                     input int unsigned addr_w);
    logic range_bad;
    range_bad = (addr_w < 32) ? ((addr >> addr_w) != 32'd0) : 1'b0;
    return (rd == wr) || (addr[1:0] != 2'b00) || range_bad;
  endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Word-wide backing store built from four byte-lane arrays (lane0 = Data[31:24]).
// One synchronous word write port and one registered word read port on a shared index.
module mem_word_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-3:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [7:0] lane0 [DEPTH];
  logic [7:0] lane1 [DEPTH];
  logic [7:0] lane2 [DEPTH];
  logic [7:0] lane3 [DEPTH];

  // NOTE: the storage arrays have no reset; contents survive a bus reset and
  // a reset loop over every entry would not map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      lane0[idx] <= wdata[31:24];
      lane1[idx] <= wdata[23:16];
      lane2[idx] <= wdata[15:8];
      lane3[idx] <= wdata[7:0];
    end
    if (re) begin
      rdata <= {lane0[idx], lane1[idx], lane2[idx], lane3[idx]};
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the BIU external bus: captures a word request in IDLE,
// waits WAIT_STATES+1 cycles, then holds rdy (and read data) until cs is dropped.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        W_Clk,
  input  logic        reset,
  input  logic        mem_cs,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] Addr,
  inout  wire  [31:0] Data,
  output logic        mem_rdy,
  output logic        mem_err
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               capture, enter_resp;

  logic [ADDR_W-3:0]  idx_q, idx_cur;
  op_t                op_q, op_live, op_cur;
  logic [DATA_W-1:0]  wdata_q, wdata_cur;
  logic               err_q, err_live, err_cur;

  logic               ram_we, ram_re;
  logic [DATA_W-1:0]  rdata;
  logic               data_oe;
  logic [DATA_W-1:0]  data_out;

  // Reads win the op code when both strobes are set; the request faults anyway.
  assign op_live  = mem_rd ? OP_RD : OP_WR;
  assign err_live = req_fault(mem_rd, mem_wr, Addr, ADDR_W);

  // With zero wait states RESP is entered on the capture edge itself, so the
  // memory port must see the live bus rather than the request latch.
  assign idx_cur   = (state == ST_IDLE) ? Addr[ADDR_W-1:2] : idx_q;
  assign op_cur    = (state == ST_IDLE) ? op_live          : op_q;
  assign wdata_cur = (state == ST_IDLE) ? Data             : wdata_q;
  assign err_cur   = (state == ST_IDLE) ? err_live         : err_q;

  always_ff @(posedge W_Clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      op_q    <= OP_RD;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        idx_q   <= Addr[ADDR_W-1:2];
        op_q    <= op_live;
        wdata_q <= Data;
        err_q   <= err_live;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_cs) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (!mem_cs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Faulted requests never touch memory; reset aborts any pending commit.
  assign ram_we = enter_resp && !reset && (op_cur == OP_WR) && !err_cur;
  assign ram_re = enter_resp && !reset && (op_cur == OP_RD) && !err_cur;

  mem_word_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (W_Clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (idx_cur),
    .wdata (wdata_cur),
    .rdata (rdata)
  );

  assign mem_rdy  = (state == ST_RESP);
  assign mem_err  = (state == ST_RESP) && err_q;

  // The bus is only driven while the BIU is still asking for read data.
  assign data_oe  = (state == ST_RESP) && (op_q == OP_RD) && mem_rd;
  assign data_out = err_q ? '0 : rdata;
  assign Data     = data_oe ? data_out : 'z;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed vector table, hand-written
// handshake/reset sequences and a randomized pass against a word-level memory model.
module tb_mem_bus_responder;

  localparam int AW = 12;
  localparam int WS = 1;

  logic        W_Clk = 1'b0;
  logic        reset;
  logic        mem_cs, mem_rd, mem_wr;
  logic [31:0] Addr;
  logic [31:0] tb_data;
  logic        tb_oe;
  wire  [31:0] Data;
  logic        mem_rdy, mem_err;

  int errors = 0;
  int checks = 0;

  assign Data = tb_oe ? tb_data : 'z;

  mem_bus_responder #(
    .ADDR_W      (AW),
    .WAIT_STATES (WS)
  ) dut (
    .W_Clk   (W_Clk),
    .reset   (reset),
    .mem_cs  (mem_cs),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .Addr    (Addr),
    .Data    (Data),
    .mem_rdy (mem_rdy),
    .mem_err (mem_err)
  );

  always #5 W_Clk = ~W_Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller must be positioned at a negedge; returns after the capture edge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    mem_cs  = 1'b1;
    mem_rd  = rd;
    mem_wr  = wr;
    Addr    = addr;
    tb_data = wdata;
    tb_oe   = !rd;
    @(posedge W_Clk);
  endtask

  // Counts edges from capture to mem_rdy; scrambles address/data meanwhile.
  task automatic wait_rdy(input string name, output int lat);
    lat = 0;
    forever begin
      @(negedge W_Clk);
      if (lat == 0) begin
        check({name, " no drive in WAIT"}, {31'd0, dut.data_oe}, 32'd0);
        Addr    = $urandom;
        tb_data = $urandom;
      end
      if (mem_rdy) break;
      @(posedge W_Clk);
      lat++;
      if (lat > 40) begin
        check({name, " rdy timeout"}, 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic release_bus(input string name);
    mem_cs = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    tb_oe  = 1'b0;
    @(posedge W_Clk);
    @(negedge W_Clk);
    check({name, " rdy low after cs drop"}, {31'd0, mem_rdy}, 32'd0);
    check({name, " bus released"}, {31'd0, dut.data_oe}, 32'd0);
  endtask

  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] data, output logic err, output int lat);
    @(negedge W_Clk);
    issue(rd, wr, addr, wdata);
    wait_rdy(name, lat);
    data = Data;
    err  = mem_err;
    release_bus(name);
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] model [int];

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;

    reset  = 1'b1;
    mem_cs = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    Addr   = '0;
    tb_data = '0;
    tb_oe  = 1'b0;

    vecs[0]  = '{"wr deadbeef",   1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"rd 010",        1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{"wr 11223344",   1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{"wr 000",        1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"rd misaligned", 1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[5]  = '{"rd 010 again",  1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{"wr out of rng", 1'b0, 1'b1, 32'h0000_1000, 32'h55AA_55AA, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{"rd 000",        1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0BAD_C0DE};
    vecs[8]  = '{"rd+wr",         1'b1, 1'b1, 32'h0000_0030, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[9]  = '{"no strobe",     1'b0, 1'b0, 32'h0000_0030, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[10] = '{"rd 020",        1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 1'b1, 32'h1122_3344};
    vecs[11] = '{"rd hi addr",    1'b1, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[12] = '{"wr 040",        1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 1'b0, 32'h0};

    repeat (3) @(posedge W_Clk);
    @(negedge W_Clk);
    check("reset rdy", {31'd0, mem_rdy}, 32'd0);
    check("reset err", {31'd0, mem_err}, 32'd0);
    check("reset no drive", {31'd0, dut.data_oe}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      access(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e, lat);
      check({vecs[i].name, " latency"}, lat, WS + 1);
      check({vecs[i].name, " err"}, {31'd0, e}, {31'd0, vecs[i].exp_err});
      if (vecs[i].chk_data) check({vecs[i].name, " data"}, d, vecs[i].exp_data);
    end

    check("byte 020", {24'd0, dut.u_ram.lane0[8]}, 32'h11);
    check("byte 023", {24'd0, dut.u_ram.lane3[8]}, 32'h44);

    // Hold cs after rdy, then drop it and start the next request straight away.
    @(negedge W_Clk);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    wait_rdy("hold", lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge W_Clk);
      @(negedge W_Clk);
      check("hold rdy", {31'd0, mem_rdy}, 32'd1);
      check("hold data", Data, 32'hDEAD_BEEF);
    end
    release_bus("hold");
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    wait_rdy("b2b", lat);
    check("b2b latency", lat, WS + 1);
    check("b2b data", Data, 32'h1122_3344);
    release_bus("b2b");

    // Reset during WAIT of a write must abort it.
    @(negedge W_Clk);
    issue(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);
    @(negedge W_Clk);
    reset  = 1'b1;
    mem_cs = 1'b0;
    mem_wr = 1'b0;
    tb_oe  = 1'b0;
    @(posedge W_Clk);
    @(negedge W_Clk);
    check("abort rdy", {31'd0, mem_rdy}, 32'd0);
    check("abort no drive", {31'd0, dut.data_oe}, 32'd0);
    reset = 1'b0;
    access("after abort", 1'b1, 1'b0, 32'h0000_0040, 32'h0, d, e, lat);
    check("after abort data", d, 32'h1234_5678);
    check("after abort err", {31'd0, e}, 32'd0);

    // Randomized traffic against a word-level model of the store.
    for (int n = 0; n < 60; n++) begin
      logic        rd, wr, exp_err;
      logic [31:0] addr, wdata;
      int          kind;
      kind  = $urandom_range(0, 9);
      addr  = 32'h200 + 4 * $urandom_range(0, 15);
      wdata = $urandom;
      rd    = $urandom_range(0, 1);
      wr    = !rd;
      case (kind)
        0: addr = addr | 32'($urandom_range(1, 3));
        1: addr = addr | (32'd1 << $urandom_range(AW, 31));
        2: begin rd = 1'b1; wr = 1'b1; end
        3: begin rd = 1'b0; wr = 1'b0; end
        default: ;
      endcase
      exp_err = (rd == wr) || (addr % 4 != 0) || (addr >= 32'(1 << AW));
      access("rand", rd, wr, addr, wdata, d, e, lat);
      check("rand latency", lat, WS + 1);
      check("rand err", {31'd0, e}, {31'd0, exp_err});
      if (rd && exp_err) check("rand err data", d, 32'h0);
      else if (rd && model.exists(int'(addr))) check("rand data", d, model[int'(addr)]);
      if (wr && !exp_err) model[int'(addr)] = wdata;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
